// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity selectors and default widths.
package uart_pkg;

  localparam int unsigned UART_DATA_WIDTH     = 8;
  localparam int unsigned UART_PRESCALE_WIDTH = 6;
  localparam int unsigned MIN_PRESCALE        = 2;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Per-bit edge counter for the UART transmitter; latches the prescale at frame accept
// and flags the last oversampled cycle of every bit.
module uart_tx_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned PRESCALE_WIDTH = UART_PRESCALE_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic                      run,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      bit_end_c,
  output logic                      bit_near_end_c
);

  localparam int unsigned PW = PRESCALE_WIDTH;

  logic [PW-1:0] ps_q, ps_d;
  logic [PW-1:0] edge_cnt_q, edge_cnt_d;

  assign bit_end_c      = run && (edge_cnt_q == ps_q - PW'(1));
  assign bit_near_end_c = run && (edge_cnt_q == ps_q - PW'(2));

  // Prescales below the minimum are clamped so a bit always spans at least two cycles.
  always_comb begin
    ps_d       = ps_q;
    edge_cnt_d = edge_cnt_q;
    if (load) begin
      ps_d       = (prescale < PW'(MIN_PRESCALE)) ? PW'(MIN_PRESCALE) : prescale;
      edge_cnt_d = '0;
    end else if (!run || bit_end_c) begin
      edge_cnt_d = '0;
    end else begin
      edge_cnt_d = edge_cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ps_q       <= '0;
      edge_cnt_q <= '0;
    end else begin
      ps_q       <= ps_d;
      edge_cnt_q <= edge_cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame_generator.sv
// UART transmitter: serialises one latched byte LSB-first as start, data, optional
// parity and stop, each bit held for the latched prescale count of cycles.
module uart_tx_frame_generator
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = UART_DATA_WIDTH,
  parameter int unsigned PRESCALE_WIDTH = UART_PRESCALE_WIDTH
) (
  input  logic                      clk_based_on_prescale,
  input  logic                      rst,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      data_valid,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  output logic                      TX_OUT,
  output logic                      busy,
  output logic                      tx_done
);

  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  tx_state_e              state_q, state_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   par_en_q, par_en_d;
  logic                   par_typ_q, par_typ_d;
  logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
  logic                   tx_out_q, tx_out_d;
  logic                   busy_q, busy_d;
  logic                   tx_done_q, tx_done_d;

  logic accept_c;
  logic run_c;
  logic bit_end_c;
  logic bit_near_end_c;
  logic parity_c;

  assign run_c    = (state_q != IDLE);
  assign parity_c = (^data_d) ^ (par_typ_d == PAR_ODD);

  uart_tx_bit_timer #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_bit_timer (
    .clk            (clk_based_on_prescale),
    .rst            (rst),
    .load           (accept_c),
    .run            (run_c),
    .prescale       (prescale),
    .bit_end_c      (bit_end_c),
    .bit_near_end_c (bit_near_end_c)
  );

  // Next-state and latched fields; outputs are then derived from the next state so
  // the registered line changes on the same edge as the FSM.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    bit_idx_d = bit_idx_q;
    tx_done_d = 1'b0;
    accept_c  = 1'b0;

    case (state_q)
      IDLE: begin
        if (data_valid) begin
          accept_c  = 1'b1;
          data_d    = P_DATA;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          bit_idx_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_end_c) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end_c) begin
          if (bit_idx_q == IDX_W'(DATA_WIDTH - 1)) begin
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end_c) begin
          state_d = STOP;
        end
      end
      STOP: begin
        tx_done_d = bit_near_end_c;
        if (bit_end_c) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    tx_out_d = 1'b1;
    busy_d   = 1'b1;
    case (state_d)
      IDLE:    busy_d   = 1'b0;
      START:   tx_out_d = 1'b0;
      DATA:    tx_out_d = data_d[bit_idx_d];
      PARITY:  tx_out_d = parity_c;
      STOP:    tx_out_d = 1'b1;
      default: begin
        tx_out_d = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_based_on_prescale) begin
    if (rst) begin
      state_q   <= IDLE;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      bit_idx_q <= '0;
      tx_out_q  <= 1'b1;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      bit_idx_q <= bit_idx_d;
      tx_out_q  <= tx_out_d;
      busy_q    <= busy_d;
      tx_done_q <= tx_done_d;
    end
  end

  assign TX_OUT  = tx_out_q;
  assign busy    = busy_q;
  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx_frame_generator.sv
// Scoreboard bench for uart_tx_frame_generator: stimulus queues expected frames,
// a negedge monitor captures each busy window and compares it to the frame model.
module tb_uart_tx_frame_generator;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] prescale;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       busy;
  logic       tx_done;

  always #5 clk = ~clk;

  uart_tx_frame_generator dut (
    .clk_based_on_prescale (clk),
    .rst                   (rst),
    .prescale              (prescale),
    .P_DATA                (P_DATA),
    .data_valid            (data_valid),
    .PAR_EN                (PAR_EN),
    .PAR_TYP               (PAR_TYP),
    .TX_OUT                (TX_OUT),
    .busy                  (busy),
    .tx_done               (tx_done)
  );

  typedef struct {
    logic [7:0] data;
    bit         pe;
    bit         pt;
    int         ps;
    int         abort_len;  // 0 = full frame, else busy cycles before reset cut it
    int         gap;        // 0 = don't care, else required idle cycles before it
  } frame_t;

  frame_t exp_q[$];
  bit     cap_tx[$];
  bit     cap_done[$];
  int     checks = 0;
  int     errors = 0;
  bit     prev_busy = 1'b0;
  int     low_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame model: start, LSB-first data, parity making the total ones count even/odd, stop.
  task automatic process_frame();
    frame_t f;
    bit     bits[$];
    bit     par;
    int     total, exp_len, lim, bad, done_bad;
    if (exp_q.size() == 0) begin
      check("unexpected_frame_len", cap_tx.size(), 0);
      return;
    end
    f = exp_q.pop_front();
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(f.data[i]);
    if (f.pe) begin
      par = (($countones(f.data) % 2) == 1) ^ f.pt;
      bits.push_back(par);
    end
    bits.push_back(1'b1);
    total   = bits.size() * f.ps;
    exp_len = (f.abort_len != 0) ? f.abort_len : total;
    check($sformatf("busy_len data=%02h", f.data), cap_tx.size(), exp_len);
    lim = (cap_tx.size() < exp_len) ? cap_tx.size() : exp_len;
    for (int b = 0; b < bits.size(); b++) begin
      if (b * f.ps >= lim) break;
      bad = 0;
      for (int c = b * f.ps; c < (b + 1) * f.ps && c < lim; c++)
        if (cap_tx[c] != bits[b]) bad++;
      check($sformatf("bit%0d data=%02h exp=%0d bad_cycles", b, f.data, bits[b]), bad, 0);
    end
    done_bad = 0;
    for (int c = 0; c < cap_done.size(); c++)
      if (cap_done[c] != ((f.abort_len == 0) && (c == total - 1))) done_bad++;
    check($sformatf("tx_done_pattern data=%02h bad_cycles", f.data), done_bad, 0);
    check("idle_tx_out", int'(TX_OUT), 1);
    check("idle_tx_done", int'(tx_done), 0);
  endtask

  always @(negedge clk) begin
    if (busy === 1'b1) begin
      if (!prev_busy) begin
        cap_tx.delete();
        cap_done.delete();
        if (exp_q.size() > 0 && exp_q[0].gap > 0) check("idle_gap", low_cnt, exp_q[0].gap);
      end
      cap_tx.push_back(TX_OUT);
      cap_done.push_back(tx_done);
    end else begin
      if (prev_busy) begin
        process_frame();
        low_cnt = 1;
      end else begin
        low_cnt++;
      end
    end
    prev_busy = (busy === 1'b1);
  end

  function automatic int frame_len(input bit pe, input int ps);
    return (10 + int'(pe)) * ps;
  endfunction

  task automatic send(input logic [7:0] d, input bit pe, input bit pt, input int ps,
                      input bit mid_pulse);
    @(negedge clk);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; prescale = 6'(ps); data_valid = 1'b1;
    exp_q.push_back('{data: d, pe: pe, pt: pt, ps: ps, abort_len: 0, gap: 0});
    @(negedge clk);
    data_valid = 1'b0;
    P_DATA = 8'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
    prescale = 6'($urandom);
    if (mid_pulse) begin
      repeat (100) @(negedge clk);
      P_DATA = 8'h3C; data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
    end
    repeat (frame_len(pe, ps) + 2) @(negedge clk);
  endtask

  initial begin
    int ps_opts[3] = '{8, 16, 32};
    rst = 1'b1; data_valid = 1'b0; P_DATA = '0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    prescale = 6'd8;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_tx_out", int'(TX_OUT), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_tx_done", int'(tx_done), 0);

    send(8'hA5, 1'b1, 1'b0, 8, 1'b0);
    send(8'hA5, 1'b1, 1'b1, 8, 1'b0);
    send(8'h00, 1'b0, 1'b0, 16, 1'b0);
    send(8'hFF, 1'b1, 1'b0, 32, 1'b1);

    // Request held high across two frames: exactly one idle-high cycle between them.
    @(negedge clk);
    P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = 6'd8; data_valid = 1'b1;
    exp_q.push_back('{data: 8'h55, pe: 1'b0, pt: 1'b0, ps: 8, abort_len: 0, gap: 0});
    exp_q.push_back('{data: 8'hAA, pe: 1'b0, pt: 1'b0, ps: 8, abort_len: 0, gap: 1});
    @(negedge clk);
    P_DATA = 8'hAA;
    repeat (81) @(negedge clk);
    data_valid = 1'b0;
    repeat (85) @(negedge clk);

    // Reset during data bit 3: the frame is cut after 35 busy cycles with no tx_done.
    @(negedge clk);
    P_DATA = 8'hC3; PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = 6'd8; data_valid = 1'b1;
    exp_q.push_back('{data: 8'hC3, pe: 1'b0, pt: 1'b0, ps: 8, abort_len: 35, gap: 0});
    @(negedge clk);
    data_valid = 1'b0;
    repeat (34) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send(8'h81, 1'b0, 1'b0, 8, 1'b0);

    // Reset and request together: no frame may start.
    @(negedge clk);
    rst = 1'b1; data_valid = 1'b1; P_DATA = 8'h99;
    @(negedge clk);
    rst = 1'b0; data_valid = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 10; i++)
      send(8'($urandom), 1'($urandom), 1'($urandom), ps_opts[$urandom_range(0, 2)], 1'b0);

    repeat (5) @(negedge clk);
    check("pending_frames", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
